pagerank_update_arbiter: RTL and testbench

Round-robin controller that shares one `pagerank_local_update` unit among `NUM_THREADS` scatter threads. It accepts (destination id, scatter page rank) requests from each thread and issues them one at a time to the update unit. It waits for each update to complete before issuing the next. Once every thread reports done and no work remains, it signals that the gather phase is finished. It sits between the per-thread scatter engines and the single update/adder datapath.

---
 rtl/pagerank_update_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pagerank_update_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pagerank_update_arbiter.sv
// pagerank_update_arbiter
//
// Round-robin front end that shares one pagerank_local_update unit among
// NUM_THREADS scatter threads. Requests are granted one at a time. The next
// request is issued only after the update unit reports that the current one
// has completed. When every thread reports done and no request is pending, the
// gather phase is flagged as complete.
//
// Ports
//   clock, reset                synchronous active-high reset
//   pagerank_enable             global stall; when low, all state holds
//   next_iteration              one-cycle pulse that clears the iteration state
//   req_valid/rank/dest_id      per-thread request, held until req_ack
//   req_ack                     one-cycle capture pulse per thread
//   thread_done                 per-thread level, no more requests this iteration
//   upd_page_rank/upd_dest_id   operands to the update unit
//   upd_ready                   one-cycle issue strobe to the update unit
//   upd_complete                the update unit finished the issued update
//   upd_next_iteration          registered copy of next_iteration
//   grant_id                    thread of the most recent grant
//   busy                        an update is being issued or is outstanding
//   update_count                updates completed this iteration (wraps)
//   gather_operation_complete   level, high once the iteration is drained
module pagerank_update_arbiter #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pagerank_enable,
  input  logic                         next_iteration,
  input  logic [NUM_THREADS-1:0]       req_valid,
  input  logic [NUM_THREADS-1:0][63:0] req_rank,
  input  logic [NUM_THREADS-1:0][31:0] req_dest_id,
  output logic [NUM_THREADS-1:0]       req_ack,
  input  logic [NUM_THREADS-1:0]       thread_done,
  output logic [63:0]                  upd_page_rank,
  output logic [31:0]                  upd_dest_id,
  output logic                         upd_ready,
  input  logic                         upd_complete,
  output logic                         upd_next_iteration,
  output logic [TID_W-1:0]             grant_id,
  output logic                         busy,
  output logic [31:0]                  update_count,
  output logic                         gather_operation_complete
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Parking last_grant on the highest index makes thread 0 the first winner.
  localparam logic [TID_W-1:0]       LastTid = TID_W'(NUM_THREADS - 1);
  localparam logic [NUM_THREADS-1:0] OneHot0 = NUM_THREADS'(1);

  logic [1:0]       state_q, state_d;
  logic [TID_W-1:0] last_grant_q, last_grant_d;
  logic [TID_W-1:0] grant_id_q, grant_id_d;
  logic [63:0]      rank_q, rank_d;
  logic [31:0]      dest_q, dest_d;
  logic [31:0]      count_q, count_d;
  logic             sticky_q, sticky_d;
  logic             next_iter_q, next_iter_d;

  logic             pick_found;
  logic [TID_W-1:0] pick_idx;
  logic [TID_W-1:0] cand_idx;

  // Walk the requesters starting just after the previous winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      cand_idx = TID_W'((32'(last_grant_q) + i) % NUM_THREADS);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    rank_d       = rank_q;
    dest_d       = dest_q;
    count_d      = count_q;
    sticky_d     = sticky_q;
    next_iter_d  = 1'b0;

    if (next_iteration) begin
      // Abandons any outstanding update; operands and grant_id are kept.
      state_d      = StIdle;
      last_grant_d = LastTid;
      count_d      = '0;
      sticky_d     = 1'b0;
      next_iter_d  = 1'b1;
    end else if (!pagerank_enable) begin
      // Remember a completion that lands while stalled so it is not lost.
      if (state_q == StWait && upd_complete) begin
        sticky_d = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_d      = StIssue;
            last_grant_d = pick_idx;
            grant_id_d   = pick_idx;
            rank_d       = req_rank[pick_idx];
            dest_d       = req_dest_id[pick_idx];
          end else if (&thread_done) begin
            state_d = StDone;
          end
        end
        StIssue: state_d = StWait;
        StWait: begin
          if (upd_complete || sticky_q) begin
            state_d  = StIdle;
            count_d  = count_q + 32'd1;
            sticky_d = 1'b0;
          end
        end
        default: state_d = state_q;  // StDone holds until next_iteration
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= LastTid;
      grant_id_q   <= '0;
      rank_q       <= '0;
      dest_q       <= '0;
      count_q      <= '0;
      sticky_q     <= 1'b0;
      next_iter_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      rank_q       <= rank_d;
      dest_q       <= dest_d;
      count_q      <= count_d;
      sticky_q     <= sticky_d;
      next_iter_q  <= next_iter_d;
    end
  end

  // Strobes are gated so a stalled issue cycle is presented again on resume.
  assign upd_ready                 = pagerank_enable && (state_q == StIssue);
  assign req_ack                   = upd_ready ? (OneHot0 << grant_id_q) : '0;
  assign upd_page_rank             = rank_q;
  assign upd_dest_id               = dest_q;
  assign grant_id                  = grant_id_q;
  assign update_count              = count_q;
  assign upd_next_iteration        = next_iter_q;
  assign busy                      = (state_q == StIssue) || (state_q == StWait);
  assign gather_operation_complete = (state_q == StDone);

endmodule

// File: tb/tb_pagerank_update_arbiter.sv
// Self-checking bench for pagerank_update_arbiter: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against a
// transaction-level model of the arbiter kept in this file.
module tb_pagerank_update_arbiter;

  localparam int N  = 4;
  localparam int TW = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                pagerank_enable = 1'b1;
  logic                next_iteration = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][63:0]  req_rank = '0;
  logic [N-1:0][31:0]  req_dest_id = '0;
  logic [N-1:0]        req_ack;
  logic [N-1:0]        thread_done = '0;
  logic [63:0]         upd_page_rank;
  logic [31:0]         upd_dest_id;
  logic                upd_ready;
  logic                upd_complete;
  logic                upd_next_iteration;
  logic [TW-1:0]       grant_id;
  logic                busy;
  logic [31:0]         update_count;
  logic                gather_operation_complete;

  logic auto_complete = 1'b0;
  logic man_complete  = 1'b0;
  logic resp_auto     = 1'b0;
  assign upd_complete = auto_complete | man_complete;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;
  logic [N-1:0] ack_seen = '0;

  pagerank_update_arbiter #(.NUM_THREADS(N), .TID_W(TW)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .pagerank_enable           (pagerank_enable),
    .next_iteration            (next_iteration),
    .req_valid                 (req_valid),
    .req_rank                  (req_rank),
    .req_dest_id               (req_dest_id),
    .req_ack                   (req_ack),
    .thread_done               (thread_done),
    .upd_page_rank             (upd_page_rank),
    .upd_dest_id               (upd_dest_id),
    .upd_ready                 (upd_ready),
    .upd_complete              (upd_complete),
    .upd_next_iteration        (upd_next_iteration),
    .grant_id                  (grant_id),
    .busy                      (busy),
    .update_count              (update_count),
    .gather_operation_complete (gather_operation_complete)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Nearest requester above the previous winner, else the lowest-numbered one.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int pick;
    pick = -1;
    for (int i = N - 1; i > last; i--) if (v[i]) pick = i;
    if (pick < 0) for (int i = last; i >= 0; i--) if (v[i]) pick = i;
    return pick;
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit            m_issuing, m_outstanding, m_finished, m_credit, m_nip;
  int            m_last;
  logic [TW-1:0] m_gid;
  logic [63:0]   m_rank;
  logic [31:0]   m_dest;
  logic [31:0]   m_count;

  always @(posedge clock) begin
    if (reset) begin
      m_issuing = 0; m_outstanding = 0; m_finished = 0; m_credit = 0; m_nip = 0;
      m_last = N - 1; m_gid = '0; m_rank = '0; m_dest = '0; m_count = '0;
    end else if (next_iteration) begin
      m_issuing = 0; m_outstanding = 0; m_finished = 0; m_credit = 0; m_nip = 1;
      m_last = N - 1; m_count = '0;
    end else begin
      m_nip = 0;
      if (!pagerank_enable) begin
        if (m_outstanding && upd_complete) m_credit = 1;
      end else if (m_issuing) begin
        m_issuing = 0;
        m_outstanding = 1;
      end else if (m_outstanding) begin
        if (upd_complete || m_credit) begin
          m_outstanding = 0;
          m_credit = 0;
          m_count = m_count + 32'd1;
        end
      end else if (!m_finished) begin
        if (req_valid != '0) begin
          m_last = rr_pick(req_valid, m_last);
          m_gid = TW'(m_last);
          m_rank = req_rank[m_gid];
          m_dest = req_dest_id[m_gid];
          m_issuing = 1;
        end else if (&thread_done) begin
          m_finished = 1;
        end
      end
    end
  end

  // Per-cycle comparison, mid-cycle.
  always @(negedge clock) begin
    logic         exp_ready;
    logic [N-1:0] exp_ack;
    if (chk_on) begin
      exp_ready = m_issuing && pagerank_enable;
      exp_ack   = exp_ready ? (N'(1) << m_gid) : '0;
      check("upd_ready", 64'(upd_ready), 64'(exp_ready));
      check("req_ack", 64'(req_ack), 64'(exp_ack));
      check("upd_page_rank", upd_page_rank, m_rank);
      check("upd_dest_id", 64'(upd_dest_id), 64'(m_dest));
      check("grant_id", 64'(grant_id), 64'(m_gid));
      check("busy", 64'(busy), 64'(m_issuing || m_outstanding));
      check("update_count", 64'(update_count), 64'(m_count));
      check("gather_complete", 64'(gather_operation_complete), 64'(m_finished));
      check("upd_next_iteration", 64'(upd_next_iteration), 64'(m_nip));
    end
  end

  always @(negedge clock) ack_seen = req_ack;

  // Update-unit responder: completes 0..3 cycles into the wait.
  int resp_timer = 0;
  initial forever begin
    @(negedge clock);
    if (resp_auto && upd_ready) resp_timer = 1 + int'($urandom_range(0, 3));
    @(posedge clock);
    #2;
    auto_complete = 1'b0;
    if (resp_timer > 0) begin
      resp_timer--;
      if (resp_timer == 0) auto_complete = resp_auto;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_next_iteration();
    next_iteration = 1'b1;
    step(1);
    next_iteration = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_idle: busy stuck at 1, expected 0 within 50 cycles");
    end
  endtask

  task automatic serve(input int t, input logic [63:0] r, input logic [31:0] d);
    bit got;
    got = 1'b0;
    req_rank[t] = r;
    req_dest_id[t] = d;
    req_valid[t] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      step(1);
      if (req_ack[t]) got = 1'b1;
    end
    req_valid[t] = 1'b0;
    if (!got) begin
      miscompares++;
      $display("FAIL serve_ack: thread %0d never acked, expected an ack", t);
    end
    step(1);
    wait_idle();
  endtask

  task automatic rand_cycle(input bit winding);
    pagerank_enable = ($urandom_range(0, 7) != 0);
    next_iteration  = !winding && ($urandom_range(0, 63) == 0);
    thread_done     = winding ? '1 : (($urandom_range(0, 39) == 0) ? '1 : '0);
    for (int t = 0; t < N; t++) begin
      if (req_valid[t] && ack_seen[t]) begin
        req_valid[t] = !winding && ($urandom_range(0, 1) == 1);
        req_rank[t] = {$urandom, $urandom};
        req_dest_id[t] = $urandom;
      end else if (!req_valid[t] && !winding && $urandom_range(0, 3) == 0) begin
        req_valid[t] = 1'b1;
        req_rank[t] = {$urandom, $urandom};
        req_dest_id[t] = $urandom;
      end
    end
    step(1);
  endtask

  initial begin
    int got_q[$];
    int exp_order[6];
    bit done_seen;
    exp_order = '{0, 1, 2, 3, 0, 1};

    // Reset values.
    step(1);
    chk_on = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(update_count), 64'd0);
    check("rst_gather", 64'(gather_operation_complete), 64'd0);
    reset = 1'b0;
    step(1);

    // Single request from thread 2.
    req_rank[2] = 64'h3FF0000000000000;
    req_dest_id[2] = 32'd5;
    req_valid[2] = 1'b1;
    step(1);
    check("single_ready", 64'(upd_ready), 64'd1);
    check("single_ack", 64'(req_ack), 64'b0100);
    check("single_rank", upd_page_rank, 64'h3FF0000000000000);
    check("single_dest", 64'(upd_dest_id), 64'd5);
    check("single_gid", 64'(grant_id), 64'd2);
    req_valid[2] = 1'b0;
    step(4);
    man_complete = 1'b1;
    step(1);
    man_complete = 1'b0;
    check("single_count", 64'(update_count), 64'd1);
    check("single_idle", 64'(busy), 64'd0);

    // Fairness with all threads requesting continuously.
    pulse_next_iteration();
    resp_auto = 1'b1;
    for (int t = 0; t < N; t++) begin
      req_rank[t] = 64'h100 + 64'(t);
      req_dest_id[t] = 32'(t);
    end
    req_valid = '1;
    for (int k = 0; k < 100 && got_q.size() < 6; k++) begin
      step(1);
      for (int t = 0; t < N; t++) if (req_ack[t]) got_q.push_back(t);
    end
    req_valid = '0;
    if (got_q.size() < 6) begin
      miscompares++;
      $display("FAIL fair_count: got %0d grants, expected 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) check("fair_order", 64'(got_q[i]), 64'(exp_order[i]));
    end
    step(1);
    wait_idle();

    // Completion after three served requests.
    pulse_next_iteration();
    serve(0, 64'hA, 32'd10);
    serve(1, 64'hB, 32'd11);
    serve(2, 64'hC, 32'd12);
    check("done_count", 64'(update_count), 64'd3);
    thread_done = '1;
    step(1);
    check("done_gather", 64'(gather_operation_complete), 64'd1);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("done_no_ack", 64'(req_ack), 64'd0);
    end
    check("done_held", 64'(gather_operation_complete), 64'd1);
    req_valid = '0;
    thread_done = '0;
    pulse_next_iteration();
    check("done_cleared", 64'(gather_operation_complete), 64'd0);
    resp_auto = 1'b0;

    // Enable stall during the issue cycle.
    req_rank[1] = 64'hDEAD_BEEF_0000_0001;
    req_dest_id[1] = 32'd77;
    req_valid[1] = 1'b1;
    step(1);
    pagerank_enable = 1'b0;
    #1;
    check("stall_ready_off", 64'(upd_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("stall_ready_held", 64'(upd_ready), 64'd0);
    end
    pagerank_enable = 1'b1;
    #1;
    check("stall_ready_on", 64'(upd_ready), 64'd1);
    check("stall_ack", 64'(req_ack), 64'b0010);
    step(1);
    req_valid[1] = 1'b0;
    check("stall_single_pulse", 64'(upd_ready), 64'd0);

    // Completion landing while stalled in the wait.
    pagerank_enable = 1'b0;
    man_complete = 1'b1;
    step(1);
    man_complete = 1'b0;
    step(2);
    check("sticky_hold_count", 64'(update_count), 64'd0);
    pagerank_enable = 1'b1;
    step(1);
    check("sticky_count", 64'(update_count), 64'd1);

    // Clear in the middle of a wait.
    req_valid[3] = 1'b1;
    step(1);
    check("clr_gid", 64'(grant_id), 64'd3);
    req_valid[3] = 1'b0;
    step(1);
    next_iteration = 1'b1;
    step(1);
    next_iteration = 1'b0;
    check("clr_idle", 64'(busy), 64'd0);
    check("clr_count", 64'(update_count), 64'd0);
    check("clr_nip_on", 64'(upd_next_iteration), 64'd1);
    step(1);
    check("clr_nip_off", 64'(upd_next_iteration), 64'd0);
    req_valid = '1;
    step(1);
    check("clr_first_ack", 64'(req_ack), 64'b0001);
    req_valid = '0;
    step(1);

    // Reset in the wait state.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst2_rank", upd_page_rank, 64'd0);
    check("rst2_dest", 64'(upd_dest_id), 64'd0);
    check("rst2_gid", 64'(grant_id), 64'd0);
    check("rst2_busy", 64'(busy), 64'd0);
    check("rst2_ready", 64'(upd_ready), 64'd0);

    // Randomized traffic.
    resp_auto = 1'b1;
    for (int it = 0; it < 4; it++) begin
      req_valid = '0;
      thread_done = '0;
      pulse_next_iteration();
      for (int c = 0; c < 200; c++) rand_cycle(1'b0);
      done_seen = 1'b0;
      for (int c = 0; c < 400 && !done_seen; c++) begin
        rand_cycle(1'b1);
        if (gather_operation_complete) done_seen = 1'b1;
      end
      if (!done_seen) begin
        miscompares++;
        $display("FAIL gather_timeout: gather stayed 0, expected 1 within 400 cycles");
      end
      for (int c = 0; c < 10; c++) begin
        req_valid[$urandom_range(0, N - 1)] = 1'b1;
        step(1);
      end
    end

    pagerank_enable = 1'b1;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
